// File: rtl/mm_pkg.sv
// Shared definitions for the systolic matrix-multiply engine: FSM states,
// default geometry and packed-matrix element addressing helpers.
package mm_pkg;

    localparam int DEF_W = 16;
    localparam int DEF_N = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FEED = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Row-major element index of (r,c) in an n x n matrix.
    function automatic int el_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

    // Bit offset of element (r,c) in a packed n x n matrix of w-bit elements.
    function automatic int el_lsb(input int r, input int c, input int n, input int w);
        return el_idx(r, c, n) * w;
    endfunction

endpackage

// File: rtl/mm_pe.sv
// One output-stationary MAC cell: forwards A to the right and B downward
// through registers, and accumulates the product of its current operands.
module mm_pe #(
    parameter int W     = 16,
    parameter int ACC_W = 34
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_mode,
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    output logic [W-1:0]     o_a,
    output logic [W-1:0]     o_b,
    output logic [ACC_W-1:0] o_acc
);

    logic [W-1:0]     a_q, b_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] a_ext, b_ext, prod;

    // Only the low ACC_W bits of the product are kept, so one multiplier
    // serves both modes once the operands are extended appropriately.
    assign a_ext = i_mode ? {{(ACC_W-W){i_a[W-1]}}, i_a} : {{(ACC_W-W){1'b0}}, i_a};
    assign b_ext = i_mode ? {{(ACC_W-W){i_b[W-1]}}, i_b} : {{(ACC_W-W){1'b0}}, i_b};
    assign prod  = a_ext * b_ext;
    assign acc_d = acc_q + prod;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (i_clr) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (i_en) begin
            a_q   <= i_a;
            b_q   <= i_b;
            acc_q <= acc_d;
        end
    end

    assign o_a   = a_q;
    assign o_b   = b_q;
    assign o_acc = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic multiplier: captures A and B, streams
// skewed rows/columns through an mm_pe grid, then presents C = A x B.
module systolic_mm_engine
    import mm_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int N     = DEF_N,
    parameter int ACC_W = 2*W + $clog2(N)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_mode,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [W*N*N-1:0]     i_A,
    input  logic [W*N*N-1:0]     i_B,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [ACC_W*N*N-1:0] o_C,
    output logic                 o_busy,
    output logic [1:0]           o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and o_C is held while o_valid
    // is high and i_ready is low.

    localparam int STEP_W = $clog2(3*N);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(3*N - 2);

    state_e                 state_q, state_d;
    logic [STEP_W-1:0]      step_q;
    logic [W*N*N-1:0]       a_mat_q, b_mat_q;
    logic                   mode_q;
    logic [ACC_W*N*N-1:0]   c_q, c_load;
    logic                   accept, step_en, last_step;

    logic [W-1:0]           a_edge [N];
    logic [W-1:0]           b_edge [N];
    logic [W-1:0]           a_h    [N][N-1];
    logic [W-1:0]           b_v    [N-1][N];
    logic [ACC_W-1:0]       acc    [N][N];

    assign accept    = o_ready && i_valid;
    assign step_en   = (state_q == S_FEED) && i_en;
    assign last_step = step_en && (step_q == LAST_STEP);

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_busy  = 1'b1;
        case (state_q)
            S_IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (i_valid) state_d = S_FEED;
            end
            S_FEED: if (last_step) state_d = S_DONE;
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            a_mat_q <= '0;
            b_mat_q <= '0;
            mode_q  <= 1'b0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_mat_q <= i_A;
                b_mat_q <= i_B;
                mode_q  <= i_mode;
                step_q  <= '0;
            end else if (step_en) begin
                step_q  <= step_q + 1'b1;
            end
            if (last_step) c_q <= c_load;
        end
    end

    // Row i enters A[i][step-i] on the left, column j enters B[step-j][j] on
    // top; outside the matrix the edge injects zero.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_edge[i] = '0;
            b_edge[i] = '0;
            for (int k = 0; k < N; k++) begin
                if (step_q == STEP_W'(i + k)) begin
                    a_edge[i] = a_mat_q[el_lsb(i, k, N, W) +: W];
                    b_edge[i] = b_mat_q[el_lsb(k, i, N, W) +: W];
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [W-1:0] a_in, b_in, a_out, b_out;

            if (j == 0) begin : g_a_edge
                assign a_in = a_edge[i];
            end else begin : g_a_link
                assign a_in = a_h[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in = b_edge[j];
            end else begin : g_b_link
                assign b_in = b_v[i-1][j];
            end

            // Operands leaving the right and bottom edges have no consumer.
            if (j < N-1) begin : g_a_fwd
                assign a_h[i][j] = a_out;
            end else begin : g_a_exit
                logic [W-1:0] a_exit_unused;
                assign a_exit_unused = a_out;
            end
            if (i < N-1) begin : g_b_fwd
                assign b_v[i][j] = b_out;
            end else begin : g_b_exit
                logic [W-1:0] b_exit_unused;
                assign b_exit_unused = b_out;
            end

            mm_pe #(.W(W), .ACC_W(ACC_W)) u_pe (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_en    (step_en),
                .i_clr   (accept),
                .i_mode  (mode_q),
                .i_a     (a_in),
                .i_b     (b_in),
                .o_a     (a_out),
                .o_b     (b_out),
                .o_acc   (acc[i][j])
            );

            assign c_load[el_lsb(i, j, N, ACC_W) +: ACC_W] = acc[i][j];
        end
    end

    assign o_C         = c_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine: a reference matrix product per job
// feeds an expected queue checked whenever o_valid is high.
module tb_systolic_mm_engine;
    import mm_pkg::*;

    localparam int W     = 16;
    localparam int N     = 3;
    localparam int ACC_W = 2*W + $clog2(N);
    localparam int AW    = W*N*N;
    localparam int CW    = ACC_W*N*N;

    logic          i_clk, i_rst_n, i_en, i_mode, i_valid, i_ready;
    logic [AW-1:0] i_A, i_B;
    logic          o_ready, o_valid, o_busy;
    logic [CW-1:0] o_C;
    logic [1:0]    o_dbg_state;

    systolic_mm_engine #(.W(W), .N(N), .ACC_W(ACC_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_en),
        .i_mode      (i_mode),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_A         (i_A),
        .i_B         (i_B),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_C         (o_C),
        .o_busy      (o_busy),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_q[$];

    // ---------------- reference model ----------------
    function automatic logic [CW-1:0] mm_model(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                               input logic m);
        logic [CW-1:0] res;
        res = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                longint acc;
                acc = 0;
                for (int k = 0; k < N; k++) begin
                    logic [W-1:0] ea, eb;
                    longint va, vb;
                    ea = a[el_lsb(r, k, N, W) +: W];
                    eb = b[el_lsb(k, c, N, W) +: W];
                    va = m ? longint'($signed(ea)) : longint'(ea);
                    vb = m ? longint'($signed(eb)) : longint'(eb);
                    acc = acc + va * vb;
                end
                res[el_lsb(r, c, N, ACC_W) +: ACC_W] = acc[ACC_W-1:0];
            end
        end
        return res;
    endfunction

    function automatic logic [AW-1:0] fill(input logic [W-1:0] v);
        logic [AW-1:0] m;
        for (int e = 0; e < N*N; e++) m[e*W +: W] = v;
        return m;
    endfunction

    function automatic logic [AW-1:0] ident();
        logic [AW-1:0] m;
        m = '0;
        for (int e = 0; e < N; e++) m[el_lsb(e, e, N, W) +: W] = 16'd1;
        return m;
    endfunction

    function automatic logic [AW-1:0] rand_mat();
        logic [AW-1:0] m;
        for (int e = 0; e < N*N; e++) m[e*W +: W] = W'($urandom_range(0, 16'hFFFF));
        return m;
    endfunction

    function automatic logic [ACC_W-1:0] el_of(input logic [CW-1:0] c, input int r, input int cc);
        return c[el_lsb(r, cc, N, ACC_W) +: ACC_W];
    endfunction

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                chk("result_C", o_C, exp_q[0]);
                if (i_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (!o_ready && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (!o_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_valid(input int stall_len, output int edges);
        edges = 0;
        while (!o_valid && edges < 200) begin
            @(posedge i_clk); #1;
            edges++;
            if (stall_len > 0 && edges == 2)             i_en = 1'b0;
            if (stall_len > 0 && edges == 2 + stall_len) i_en = 1'b1;
        end
        i_en = 1'b1;
    endtask

    task automatic run_job(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic m,
                           input int stall_len, input int rdy_hold, input int exp_lat);
        int            edges;
        logic [CW-1:0] held;
        i_ready = (rdy_hold == 0);
        wait_idle();
        i_A = a; i_B = b; i_mode = m; i_valid = 1'b1;
        exp_q.push_back(mm_model(a, b, m));
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_A = rand_mat(); i_B = rand_mat(); i_mode = ~m;
        wait_valid(stall_len, edges);
        chk("latency", CW'(edges), CW'(exp_lat));
        if (rdy_hold > 0) begin
            held = o_C;
            i_en = 1'b0;
            repeat (rdy_hold) begin
                @(posedge i_clk); #1;
                chk("hold_valid", o_valid, 1);
                chk("hold_ready_low", o_ready, 0);
                chk("hold_C_stable", o_C, held);
            end
            i_en = 1'b1;
            i_ready = 1'b1;
        end
        @(posedge i_clk); #1;
        chk("idle_after_hs_ready", o_ready, 1);
        chk("idle_after_hs_valid", o_valid, 0);
    endtask

    task automatic reset_mid_job();
        i_ready = 1'b1;
        wait_idle();
        i_A = fill(16'h0F0F); i_B = fill(16'h0F0F); i_mode = 1'b0; i_valid = 1'b1;
        exp_q.push_back(mm_model(i_A, i_B, 1'b0));
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("busy_before_rst", o_busy, 1);
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        exp_q.delete();
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_C", o_C, 0);
    endtask

    task automatic back_to_back();
        logic [AW-1:0] a2, b2;
        int            edges;
        i_ready = 1'b1;
        wait_idle();
        i_A = rand_mat(); i_B = rand_mat(); i_mode = 1'b1; i_valid = 1'b1;
        exp_q.push_back(mm_model(i_A, i_B, 1'b1));
        @(posedge i_clk); #1;
        a2 = rand_mat(); b2 = rand_mat();
        i_A = a2; i_B = b2; i_mode = 1'b0;
        exp_q.push_back(mm_model(a2, b2, 1'b0));
        wait_valid(0, edges);
        chk("b2b_latency1", CW'(edges), CW'(8));
        @(posedge i_clk); #1;
        chk("b2b_gap_ready", o_ready, 1);
        @(posedge i_clk); #1;
        chk("b2b_accept2_busy", o_busy, 1);
        i_valid = 1'b0;
        wait_valid(0, edges);
        chk("b2b_latency2", CW'(edges), CW'(8));
        @(posedge i_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [CW-1:0] mres;
        i_rst_n = 1'b0; i_en = 1'b1; i_mode = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_A = '0; i_B = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        chk("reset_ready", o_ready, 1);
        chk("reset_valid", o_valid, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_C", o_C, 0);

        // Hand-computed anchors for the model itself.
        mres = mm_model(fill(16'h0F0F), fill(16'h0F0F), 1'b0);
        chk("model_0f0f", CW'(el_of(mres, 1, 2)), CW'(34'h02A848A3));
        mres = mm_model(ident(), fill(16'hFFFF), 1'b1);
        chk("model_ident_signed", CW'(el_of(mres, 2, 0)), CW'(34'h3FFFFFFFF));
        mres = mm_model(ident(), fill(16'hFFFF), 1'b0);
        chk("model_ident_unsigned", CW'(el_of(mres, 0, 1)), CW'(34'h00000FFFF));

        run_job(fill(16'h0F0F), fill(16'h0F0F), 1'b0, 0, 0, 8);
        chk("c_0f0f_retained", CW'(el_of(o_C, 2, 1)), CW'(34'h02A848A3));

        run_job(ident(), fill(16'hFFFF), 1'b1, 0, 0, 8);
        chk("c_ident_signed", CW'(el_of(o_C, 1, 1)), CW'(34'h3FFFFFFFF));
        run_job(ident(), fill(16'hFFFF), 1'b0, 0, 0, 8);
        chk("c_ident_unsigned", CW'(el_of(o_C, 0, 2)), CW'(34'h00000FFFF));

        run_job(fill(16'h0F0F), fill(16'h0F0F), 1'b0, 4, 0, 12);
        chk("c_stall", CW'(el_of(o_C, 0, 0)), CW'(34'h02A848A3));

        run_job(fill(16'h0F0F), fill(16'h0F0F), 1'b0, 0, 5, 8);

        run_job(fill(16'hFFFF), fill(16'hFFFF), 1'b0, 0, 0, 8);
        chk("c_max_unsigned", CW'(el_of(o_C, 2, 2)), CW'(34'h2FFFA0003));
        run_job(fill(16'h8000), fill(16'h8000), 1'b1, 0, 0, 8);
        chk("c_min_signed", CW'(el_of(o_C, 1, 0)), CW'(34'h0C0000000));

        reset_mid_job();
        run_job(fill(16'h0F0F), fill(16'h0F0F), 1'b0, 0, 0, 8);

        back_to_back();

        for (int t = 0; t < 4; t++) begin
            run_job(rand_mat(), rand_mat(), t[0], 0, 0, 8);
        end

        repeat (3) @(posedge i_clk);
        #1;
        chk("queue_drained", CW'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_mm_engine.md
SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

Interface
REQ-001 SHALL have parameter W, default 16, element width in bits of A and B.
REQ-002 SHALL have parameter N, default 3, matrix dimension (N x N), legal range 2..8.
REQ-003 SHALL have parameter ACC_W, default 2*W+$clog2(N), C element width.
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_en  in  1  compute enable; low freezes FEED progress.
REQ-007 i_mode  in  1  0 = unsigned, 1 = signed two's-complement multiply.
REQ-008 i_valid  in  1  input matrices valid.
REQ-009 o_ready  out  1  engine can accept matrices.
REQ-010 i_A  in  W*N*N  matrix A; element (r,c) at bits [(r*N+c)*W +: W].
REQ-011 i_B  in  W*N*N  matrix B; same packing as i_A.
REQ-012 o_valid  out  1  o_C holds a complete result.
REQ-013 i_ready  in  1  downstream accepts o_C.
REQ-014 o_C  out  ACC_W*N*N  C = A x B; element (r,c) at bits [(r*N+c)*ACC_W +: ACC_W].
REQ-015 o_busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states IDLE, FEED, DONE; o_ready = (state == IDLE).
REQ-017 IDLE -> FEED on i_valid && o_ready; i_A, i_B, i_mode captured on that edge; accumulators cleared; step counter set to 0.
REQ-018 Changes on i_A, i_B, i_mode after capture SHALL NOT affect the running computation.
REQ-019 FEED: NxN output-stationary PE grid; A rows enter from left skewed by row index, B columns enter from top skewed by column index; PE(i,j) accumulates A[i][k]*B[k][j] at step t where k = t-i-j, 0 <= k < N; zero injected outside that range.
REQ-020 Step counter advances only on cycles with i_en = 1; with i_en = 0 all PE registers, operand pipelines and counter hold.
REQ-021 FEED -> DONE on the edge completing step 3N-2; o_C loaded from accumulators on that edge.
REQ-022 With i_en held high, o_valid SHALL rise exactly 3N-1 rising edges after the accepting edge (N=3: 8); each i_en-low cycle in FEED adds one cycle.
REQ-023 i_en is ignored in IDLE and DONE.
REQ-024 DONE: o_valid = 1; o_C stable while i_ready = 0; DONE -> IDLE on o_valid && i_ready; o_valid low next cycle.
REQ-025 No new input accepted in the same cycle as output handshake (o_ready low in DONE).
REQ-026 Products: mode 0 zero-extend, mode 1 sign-extend operands to ACC_W before multiply-accumulate; accumulation wraps modulo 2^ACC_W, no saturation, no overflow flag.
REQ-027 o_C retains last result after return to IDLE until the next FEED->DONE load.

Reset
REQ-028 i_rst_n = 0 at a rising edge SHALL force state IDLE, o_valid = 0, o_busy = 0, o_ready = 1 next cycle, o_C = 0, accumulators, operand pipelines and counter = 0.
REQ-029 Reset in FEED or DONE SHALL abandon the operation; no o_valid for it afterwards.
REQ-030 Reset has priority over i_valid, i_en and i_ready.

Structure
REQ-031 Package mm_pkg SHALL hold state enum, default W/N values, and element-index/slice helper functions shared with the bench.
REQ-032 One sub-module mm_pe (one MAC PE: operand pass-through registers a-right/b-down, accumulator, enable, clear, mode) SHALL be instantiated N*N times via generate.

Verification
REQ-033 Unsigned, N=3, all A/B elements 0x0F0F, i_en=1 -> o_valid on 8th edge after accept, every C element 0x002A848A3.
REQ-034 Signed, A = identity, B all 0xFFFF -> every C element 0x3FFFFFFFF; same stimulus unsigned -> every C element 0x00000FFFF.
REQ-035 Case 033 with i_en low for 4 cycles at FEED step 2 -> o_valid on 12th edge, identical C values.
REQ-036 Case 033 with i_ready low 5 cycles in DONE -> o_valid held, o_C unchanged, o_ready low; IDLE and o_ready=1 one cycle after i_ready rises.
REQ-037 i_rst_n low one cycle at FEED step 3 -> o_C = 0, o_valid never asserts for that job; new job accepted next cycle completes with correct result.
REQ-038 Two back-to-back jobs with i_valid held high and i_ready=1 -> second accept exactly one cycle after first output handshake, both results correct.
